// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
// Holds the mode encoding, default widths and the output-stage state type.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_N_IN    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_SLICE_W = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } outState_t;

    // Index width that can address n channels, never narrower than one bit.
    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the per-channel input streams and the single output stream.
// The slave modport is the multiplexer's view; master is the producers/consumer side.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int W     = DEF_W,
    parameter int SEL_W = $clog2(N_IN)
);

    logic [N_IN-1:0]   in_valid;
    logic [N_IN*W-1:0] in_data;
    logic [N_IN-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

endinterface

// File: rtl/mux_n_1_slice.sv
// Narrow N:1 multiplexer for one SLICE_W-bit slice of the data path.
// Channel 0 occupies the LSBs of i_d; an index past the last channel yields zero.
module mux_n_1_slice
    import stream_mux_pkg::*;
#(
    parameter  int N_IN    = DEF_N_IN,
    parameter  int SLICE_W = DEF_SLICE_W,
    localparam int IDX_W   = selWidth(N_IN)
) (
    input  logic [N_IN*SLICE_W-1:0] i_d,
    input  logic [IDX_W-1:0]        i_sel,
    output logic [SLICE_W-1:0]      o_y
);

    // Pick the slice belonging to the selected channel.
    always_comb begin
        o_y = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(i_sel) == i) begin
                o_y = i_d[i*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin arbitration.
// One registered output stage: one-cycle latency, full throughput, drain and
// load on the same edge.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int W       = DEF_W,
    parameter int SLICE_W = DEF_SLICE_W,
    parameter int SEL_W   = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mode,
    input  logic [SEL_W-1:0] i_sel,
    stream_mux_rr_if.slave   bus
);

    localparam int NUM_SLICES = W / SLICE_W;
    localparam int IDX_W      = selWidth(N_IN);

    logic                                     w_fixFound;
    logic [SEL_W-1:0]                         w_fixGrant;
    logic                                     w_rrFound;
    logic [SEL_W-1:0]                         w_rrGrant;
    logic                                     w_grantFound;
    logic [SEL_W-1:0]                         w_grant;
    logic                                     w_loadEn;
    logic                                     w_accept;
    logic [N_IN-1:0]                          w_inReady;
    logic                                     w_outValid;
    logic [NUM_SLICES-1:0][N_IN*SLICE_W-1:0] w_sliceD;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]      w_sliceY;
    logic [W-1:0]                             w_muxData;

    outState_t        r_state;
    outState_t        w_stateNext;
    logic [SEL_W-1:0] r_lastGrant;
    logic [SEL_W-1:0] r_outCh;
    logic [W-1:0]     r_outData;

    // Fixed mode: the selected channel wins only if it exists and is valid.
    always_comb begin
        w_fixFound = 1'b0;
        w_fixGrant = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(i_sel) == i && bus.in_valid[i]) begin
                w_fixFound = 1'b1;
                w_fixGrant = SEL_W'(i);
            end
        end
    end

    // Round-robin: first valid channel scanning upward from just after the last winner.
    always_comb begin
        w_rrFound = 1'b0;
        w_rrGrant = '0;
        for (int k = 1; k <= N_IN; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (!w_rrFound && bus.in_valid[i] &&
                    i == (int'(r_lastGrant) + k) % N_IN) begin
                    w_rrFound = 1'b1;
                    w_rrGrant = SEL_W'(i);
                end
            end
        end
    end

    // Combine the two arbiters and derive the handshake; reset blocks every ready.
    always_comb begin
        w_grantFound = (i_mode == MODE_RR) ? w_rrFound : w_fixFound;
        w_grant      = (i_mode == MODE_RR) ? w_rrGrant : w_fixGrant;
        w_loadEn     = (r_state == ST_EMPTY) || bus.out_ready;
        w_accept     = w_loadEn && w_grantFound && !rst;
        w_inReady    = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_inReady[i] = w_accept && (int'(w_grant) == i);
        end
    end

    // Regroup the packed channel words so each slice mux sees its own bits of every channel.
    always_comb begin
        w_sliceD = '0;
        for (int s = 0; s < NUM_SLICES; s++) begin
            for (int c = 0; c < N_IN; c++) begin
                w_sliceD[s][c*SLICE_W +: SLICE_W] = bus.in_data[c*W + s*SLICE_W +: SLICE_W];
            end
        end
    end

    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        mux_n_1_slice #(
            .N_IN    (N_IN),
            .SLICE_W (SLICE_W)
        ) u_slice (
            .i_d   (w_sliceD[s]),
            .i_sel (w_grant[IDX_W-1:0]),
            .o_y   (w_sliceY[s])
        );
    end

    assign w_muxData = w_sliceY;

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Whenever the stage may load, it ends up FULL exactly when something was granted.
    always_comb begin
        w_stateNext = r_state;
        if (w_loadEn) begin
            w_stateNext = w_grantFound ? ST_FULL : ST_EMPTY;
        end
    end

    // The valid flag is simply the FULL state.
    always_comb begin
        w_outValid = (r_state == ST_FULL);
    end

    // Capture the granted word and remember its channel; idle edges leave data and pointer alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outData   <= '0;
            r_outCh     <= '0;
            r_lastGrant <= SEL_W'(N_IN - 1);
        end else if (w_accept) begin
            r_outData   <= w_muxData;
            r_outCh     <= w_grant;
            r_lastGrant <= w_grant;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_ch    = r_outCh;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, hand-written
// reset/fairness sequences and randomized traffic against a reference model.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SW   = 2;
    localparam int SELW = 3;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [SELW-1:0] sel;

    int checks = 0;
    int errors = 0;

    stream_mux_rr_if #(.N_IN(N), .W(W), .SEL_W(SELW)) bus ();

    stream_mux_rr #(
        .N_IN    (N),
        .W       (W),
        .SLICE_W (SW),
        .SEL_W   (SELW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_mode (mode),
        .i_sel  (sel),
        .bus    (bus)
    );

    typedef struct {
        logic       m;
        logic [2:0] s;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] expReady;
        logic       expValid;
        logic [2:0] expCh;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[19];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic m, input logic [2:0] s, input logic [3:0] v,
                                input logic o, input logic [3:0] er, input logic ev,
                                input logic [2:0] ec, input logic [7:0] ed);
        vec_t r;
        r.m = m; r.s = s; r.v = v; r.ordy = o;
        r.expReady = er; r.expValid = ev; r.expCh = ec; r.expData = ed;
        return r;
    endfunction

    // Reference arbitration straight from the rules: -1 means nothing granted.
    function automatic int refGrant(input logic m, input int s, input logic [3:0] v, input int last);
        int c;
        if (m == MODE_FIXED) begin
            if (s < N) begin
                if (v[s]) return s;
            end
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eReady, input logic eValid,
                               input logic [2:0] eCh, input logic [7:0] eData);
        checkValue({tag, " in_ready"},  32'(bus.in_ready),  32'(eReady));
        checkValue({tag, " out_valid"}, 32'(bus.out_valid), 32'(eValid));
        checkValue({tag, " out_ch"},    32'(bus.out_ch),    32'(eCh));
        checkValue({tag, " out_data"},  32'(bus.out_data),  32'(eData));
    endtask

    task automatic applyStimulus(input logic m, input logic [2:0] s, input logic [3:0] v,
                                 input logic [31:0] d, input logic o);
        @(negedge clk);
        mode          = m;
        sel           = s;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = o;
        #1;
    endtask

    initial begin
        logic [31:0] tdata;
        logic [31:0] rd;
        logic        rm;
        logic [2:0]  rs;
        logic [3:0]  rv;
        logic        ro;
        logic [3:0]  eReady;
        int          g;
        int          ch;
        int          mValid;
        int          mCh;
        int          mLast;
        logic [7:0]  mData;
        logic        loadEn;

        tdata = 32'h44A5_2211;

        vecs[0]  = mk(0, 2, 4'b1111, 1, 4'b0100, 0, 0, 8'h00);
        vecs[1]  = mk(0, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA5);
        vecs[2]  = mk(0, 5, 4'b1111, 1, 4'b0000, 1, 2, 8'hA5);
        vecs[3]  = mk(0, 5, 4'b1111, 1, 4'b0000, 0, 2, 8'hA5);
        vecs[4]  = mk(1, 0, 4'b1111, 1, 4'b1000, 0, 2, 8'hA5);
        vecs[5]  = mk(1, 0, 4'b1111, 1, 4'b0001, 1, 3, 8'h44);
        vecs[6]  = mk(1, 0, 4'b1111, 1, 4'b0010, 1, 0, 8'h11);
        vecs[7]  = mk(1, 0, 4'b1111, 1, 4'b0100, 1, 1, 8'h22);
        vecs[8]  = mk(1, 0, 4'b1111, 1, 4'b1000, 1, 2, 8'hA5);
        vecs[9]  = mk(1, 0, 4'b1010, 1, 4'b0010, 1, 3, 8'h44);
        vecs[10] = mk(1, 0, 4'b1010, 1, 4'b1000, 1, 1, 8'h22);
        vecs[11] = mk(1, 0, 4'b1010, 1, 4'b0010, 1, 3, 8'h44);
        vecs[12] = mk(1, 0, 4'b1111, 0, 4'b0000, 1, 1, 8'h22);
        vecs[13] = mk(1, 0, 4'b1111, 0, 4'b0000, 1, 1, 8'h22);
        vecs[14] = mk(1, 0, 4'b1111, 0, 4'b0000, 1, 1, 8'h22);
        vecs[15] = mk(1, 0, 4'b1111, 0, 4'b0000, 1, 1, 8'h22);
        vecs[16] = mk(1, 0, 4'b1111, 1, 4'b0100, 1, 1, 8'h22);
        vecs[17] = mk(1, 0, 4'b0000, 1, 4'b0000, 1, 2, 8'hA5);
        vecs[18] = mk(1, 0, 4'b0000, 1, 4'b0000, 0, 2, 8'hA5);

        rst           = 1'b1;
        mode          = MODE_RR;
        sel           = '0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = tdata;
        bus.out_ready = 1'b1;

        $display("[TB] reset with all channels valid");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 4'b1111, tdata, 1);
            checkOutput("reset", 4'b0000, 0, 0, 8'h00);
        end
        @(negedge clk);
        bus.in_valid = 4'b0000;
        rst          = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].m, vecs[i].s, vecs[i].v, tdata, vecs[i].ordy);
            checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValid,
                        vecs[i].expCh, vecs[i].expData);
        end

        $display("[TB] asynchronous reset while FULL");
        applyStimulus(1, 0, 4'b1111, tdata, 0);
        checkOutput("pre-load", 4'b1000, 0, 2, 8'hA5);
        applyStimulus(1, 0, 4'b1111, tdata, 0);
        checkOutput("full", 4'b0000, 1, 3, 8'h44);
        #1 rst = 1'b1;
        #1 checkOutput("async rst", 4'b0000, 0, 0, 8'h00);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        #1 checkOutput("post rst", 4'b0001, 0, 0, 8'h00);

        $display("[TB] round-robin fairness after reset");
        for (int j = 0; j < 6; j++) begin
            ch = j % N;
            applyStimulus(1, 0, 4'b1111, tdata, 1);
            checkOutput($sformatf("fair%0d", j), 4'(1 << ((j + 1) % N)), 1, 3'(ch), tdata[ch*8 +: 8]);
        end

        $display("[TB] randomized traffic against reference model");
        @(negedge clk);
        bus.in_valid = 4'b0000;
        rst          = 1'b1;
        #2 rst = 1'b0;
        mValid = 0;
        mCh    = 0;
        mLast  = N - 1;
        mData  = 8'h00;
        for (int t = 0; t < 400; t++) begin
            rm = 1'($urandom_range(0, 1));
            rs = 3'($urandom_range(0, 5));
            rv = 4'($urandom);
            rd = $urandom;
            ro = ($urandom_range(0, 3) != 0);
            applyStimulus(rm, rs, rv, rd, ro);
            g      = refGrant(rm, int'(rs), rv, mLast);
            loadEn = (mValid == 0) || ro;
            eReady = (loadEn && g >= 0) ? 4'(1 << g) : 4'b0000;
            checkOutput($sformatf("rand%0d", t), eReady, 1'(mValid), 3'(mCh), mData);
            if (loadEn) begin
                if (g >= 0) begin
                    mValid = 1;
                    mData  = rd[g*8 +: 8];
                    mCh    = g;
                    mLast  = g;
                end else begin
                    mValid = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
